// File: rtl/redmule_tiling_engine.sv
// redmule_tiling_engine
// ---------------------------------------------------------------------------
// Multi-cycle tiling-parameter calculator for the RedMulE controller.
// The block takes the GEMM sizes M/N/K and the element format. It returns
// iteration counts, leftovers, the store count and byte strides for the
// controller register file.
//
// The array geometry is parametric and need not be a power of two. For that
// reason one shared bit-serial restoring divider and one shift-add multiplier
// are used instead of fixed shifts. The latency does not depend on the data:
//   - the three divisions take SIZE_W cycles each;
//   - the multiply takes SIZE_W cycles;
//   - the result is valid in the cycle after that.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   start_i            start request, only honoured in IDLE
//   m/n/k_size_i       GEMM sizes, captured when start is accepted
//   fmt_i              element format (Float8=0, Float16=1, Float8Alt=2,
//                      Float16Alt=3); the Float16 variants use 2 bytes/elem
//   busy_o             computation in progress
//   valid_o, ready_i   result handshake; results are held while !ready_i
//   err_o              some size was zero (all results reported as 0)
//   x_rows_iter_o      ceil(M / ARRAY_WIDTH),  x_rows_lft_o  M mod ARRAY_WIDTH
//   x_cols_iter_o      ceil(N / ARRAY_HEIGHT), x_cols_lft_o  N mod ARRAY_HEIGHT
//   w_cols_iter_o      ceil(K / TILE),         w_cols_lft_o  K mod TILE
//   tot_stores_o       x_rows_iter * w_cols_iter
//   x_d1_stride_o      N * bytes per element
//   w_d0_stride_o      K * bytes per element
// ---------------------------------------------------------------------------
module redmule_tiling_engine #(
    parameter int unsigned ARRAY_HEIGHT = 32,
    parameter int unsigned PIPE_REGS    = 1,
    parameter int unsigned SIZE_W       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [SIZE_W-1:0]     m_size_i,
    input  logic [SIZE_W-1:0]     n_size_i,
    input  logic [SIZE_W-1:0]     k_size_i,
    input  logic [1:0]            fmt_i,
    output logic                  busy_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  err_o,
    output logic [SIZE_W-1:0]     x_rows_iter_o,
    output logic [SIZE_W-1:0]     x_cols_iter_o,
    output logic [SIZE_W-1:0]     w_cols_iter_o,
    output logic [7:0]            x_rows_lft_o,
    output logic [7:0]            x_cols_lft_o,
    output logic [7:0]            w_cols_lft_o,
    output logic [2*SIZE_W-1:0]   tot_stores_o,
    output logic [2*SIZE_W-1:0]   x_d1_stride_o,
    output logic [2*SIZE_W-1:0]   w_d0_stride_o
);

    localparam int unsigned ARRAY_WIDTH = ARRAY_HEIGHT * PIPE_REGS;
    localparam int unsigned TILE        = ARRAY_HEIGHT * (PIPE_REGS + 1);
    localparam int unsigned CNT_W       = (SIZE_W > 1) ? $clog2(SIZE_W) : 1;

    localparam logic [7:0]          DIV_AH   = 8'(ARRAY_HEIGHT);
    localparam logic [7:0]          DIV_AW   = 8'(ARRAY_WIDTH);
    localparam logic [7:0]          DIV_TILE = 8'(TILE);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SIZE_W - 1);
    localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [SIZE_W-1:0]   ZERO_S   = {SIZE_W{1'b0}};
    localparam logic [2*SIZE_W-1:0] ZERO_L   = {(2*SIZE_W){1'b0}};

    // Divisors must be non-zero and must fit the 8-bit leftover fields.
    if (ARRAY_HEIGHT < 1 || ARRAY_HEIGHT > 255 || PIPE_REGS < 1 ||
        ARRAY_WIDTH > 255 || TILE > 255) begin : g_param_check
        $error("redmule_tiling_engine: ARRAY_HEIGHT, ARRAY_WIDTH and TILE must be in 1..255");
    end

    typedef enum logic [1:0] {
        FMT_FLOAT8     = 2'd0,
        FMT_FLOAT16    = 2'd1,
        FMT_FLOAT8ALT  = 2'd2,
        FMT_FLOAT16ALT = 2'd3
    } gemm_fmt_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DIV_M = 3'd1,
        DIV_N = 3'd2,
        DIV_K = 3'd3,
        MUL   = 3'd4,
        DONE  = 3'd5
    } state_e;

    state_e              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [SIZE_W-1:0]   n_r, k_r;
    logic                two_byte_r;

    // Restoring divider: quo_r starts out holding the dividend and shifts
    // the quotient bits in from the right.
    logic [SIZE_W-1:0]   quo_r;
    logic [7:0]          rem_r;
    logic [7:0]          divisor_s;
    logic [8:0]          shifted_s;
    logic                ge_s;
    logic [7:0]          rem_next_s;
    logic [SIZE_W-1:0]   quo_next_s;
    logic [SIZE_W-1:0]   iter_s;

    // Intermediate results. They stay internal until the result is published.
    logic [SIZE_W-1:0]   xr_iter_r, xc_iter_r, wc_iter_r;
    logic [7:0]          xr_lft_r, xc_lft_r, wc_lft_r;

    // Shift-add multiplier state.
    logic [2*SIZE_W-1:0] acc_r, mcand_r, acc_next_s;
    logic [SIZE_W-1:0]   mplier_r;

    logic                last_s;
    logic                size_zero_s;
    logic                two_byte_s;

    // Combinational step of the divider and multiplier, plus helper flags.
    always_comb begin
        case (state_r)
            DIV_M:   divisor_s = DIV_AW;
            DIV_N:   divisor_s = DIV_AH;
            DIV_K:   divisor_s = DIV_TILE;
            default: divisor_s = DIV_AH;
        endcase
        shifted_s = {rem_r, quo_r[SIZE_W-1]};
        ge_s      = (shifted_s >= {1'b0, divisor_s});
        // The true difference is always below the divisor (<= 255), so the
        // 8-bit wrap-around subtract gives the exact value.
        if (ge_s) begin
            rem_next_s = shifted_s[7:0] - divisor_s;
        end else begin
            rem_next_s = shifted_s[7:0];
        end
        quo_next_s = {quo_r[SIZE_W-2:0], ge_s};
        iter_s     = quo_next_s + {{(SIZE_W-1){1'b0}}, (rem_next_s != 8'd0)};
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
        last_s      = (cnt_r == CNT_LAST);
        size_zero_s = (m_size_i == ZERO_S) || (n_size_i == ZERO_S) || (k_size_i == ZERO_S);
        two_byte_s  = (fmt_i == FMT_FLOAT16) || (fmt_i == FMT_FLOAT16ALT);
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic. Each phase advances after SIZE_W steps.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_s = size_zero_s ? DONE : DIV_M;
                end else begin
                    state_s = IDLE;
                end
            end
            DIV_M: state_s = last_s ? DIV_N : DIV_M;
            DIV_N: state_s = last_s ? DIV_K : DIV_N;
            DIV_K: state_s = last_s ? MUL   : DIV_K;
            MUL:   state_s = last_s ? DONE  : MUL;
            DONE: begin
                if (ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath registers and the registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r         <= CNT_ZERO;
            n_r           <= ZERO_S;
            k_r           <= ZERO_S;
            two_byte_r    <= 1'b0;
            quo_r         <= ZERO_S;
            rem_r         <= 8'd0;
            xr_iter_r     <= ZERO_S;
            xc_iter_r     <= ZERO_S;
            wc_iter_r     <= ZERO_S;
            xr_lft_r      <= 8'd0;
            xc_lft_r      <= 8'd0;
            wc_lft_r      <= 8'd0;
            acc_r         <= ZERO_L;
            mcand_r       <= ZERO_L;
            mplier_r      <= ZERO_S;
            busy_o        <= 1'b0;
            valid_o       <= 1'b0;
            err_o         <= 1'b0;
            x_rows_iter_o <= ZERO_S;
            x_cols_iter_o <= ZERO_S;
            w_cols_iter_o <= ZERO_S;
            x_rows_lft_o  <= 8'd0;
            x_cols_lft_o  <= 8'd0;
            w_cols_lft_o  <= 8'd0;
            tot_stores_o  <= ZERO_L;
            x_d1_stride_o <= ZERO_L;
            w_d0_stride_o <= ZERO_L;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        n_r        <= n_size_i;
                        k_r        <= k_size_i;
                        two_byte_r <= two_byte_s;
                        quo_r      <= m_size_i;
                        rem_r      <= 8'd0;
                        cnt_r      <= CNT_ZERO;
                        if (size_zero_s) begin
                            valid_o       <= 1'b1;
                            err_o         <= 1'b1;
                            x_rows_iter_o <= ZERO_S;
                            x_cols_iter_o <= ZERO_S;
                            w_cols_iter_o <= ZERO_S;
                            x_rows_lft_o  <= 8'd0;
                            x_cols_lft_o  <= 8'd0;
                            w_cols_lft_o  <= 8'd0;
                            tot_stores_o  <= ZERO_L;
                            x_d1_stride_o <= ZERO_L;
                            w_d0_stride_o <= ZERO_L;
                        end else begin
                            busy_o <= 1'b1;
                        end
                    end
                end
                DIV_M, DIV_N, DIV_K: begin
                    cnt_r <= last_s ? CNT_ZERO : cnt_r + CNT_W'(1);
                    if (last_s) begin
                        // Save the result and preload the next operand.
                        rem_r <= 8'd0;
                        if (state_r == DIV_M) begin
                            xr_iter_r <= iter_s;
                            xr_lft_r  <= rem_next_s;
                            quo_r     <= n_r;
                        end else if (state_r == DIV_N) begin
                            xc_iter_r <= iter_s;
                            xc_lft_r  <= rem_next_s;
                            quo_r     <= k_r;
                        end else begin
                            wc_iter_r <= iter_s;
                            wc_lft_r  <= rem_next_s;
                            acc_r     <= ZERO_L;
                            mcand_r   <= {ZERO_S, xr_iter_r};
                            mplier_r  <= iter_s;
                        end
                    end else begin
                        quo_r <= quo_next_s;
                        rem_r <= rem_next_s;
                    end
                end
                MUL: begin
                    cnt_r    <= last_s ? CNT_ZERO : cnt_r + CNT_W'(1);
                    acc_r    <= acc_next_s;
                    mcand_r  <= {mcand_r[2*SIZE_W-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[SIZE_W-1:1]};
                    if (last_s) begin
                        busy_o        <= 1'b0;
                        valid_o       <= 1'b1;
                        err_o         <= 1'b0;
                        x_rows_iter_o <= xr_iter_r;
                        x_cols_iter_o <= xc_iter_r;
                        w_cols_iter_o <= wc_iter_r;
                        x_rows_lft_o  <= xr_lft_r;
                        x_cols_lft_o  <= xc_lft_r;
                        w_cols_lft_o  <= wc_lft_r;
                        tot_stores_o  <= acc_next_s;
                        x_d1_stride_o <= two_byte_r ? {{(SIZE_W-1){1'b0}}, n_r, 1'b0} : {ZERO_S, n_r};
                        w_d0_stride_o <= two_byte_r ? {{(SIZE_W-1){1'b0}}, k_r, 1'b0} : {ZERO_S, k_r};
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        err_o   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_redmule_tiling_engine.sv
// Self-checking bench for redmule_tiling_engine.
// Two instances share the stimulus:
//   - dut0 uses the default geometry (AH=32, PR=1);
//   - dut1 uses AH=12, PR=2.
// The stimulus side pushes the expected results from an arithmetic reference
// model into a queue. The monitor compares the results whenever the outputs
// are valid and pops the queue on the handshake.
module tb_redmule_tiling_engine;

    localparam int AH0 = 32;
    localparam int PR0 = 1;
    localparam int AH1 = 12;
    localparam int PR1 = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ready = 1'b1;
    logic [15:0] m_size = 16'd0;
    logic [15:0] n_size = 16'd0;
    logic [15:0] k_size = 16'd0;
    logic [1:0]  fmt = 2'd0;

    logic        busy[2];
    logic        valid[2];
    logic        err[2];
    logic [15:0] xr[2];
    logic [15:0] xc[2];
    logic [15:0] wc[2];
    logic [7:0]  xrl[2];
    logic [7:0]  xcl[2];
    logic [7:0]  wcl[2];
    logic [31:0] st[2];
    logic [31:0] xd[2];
    logic [31:0] wd[2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] err, xr, xc, wc, xrl, xcl, wcl, st, xd, wd;
    } res_t;

    typedef struct {
        res_t r0;
        res_t r1;
        int   acc_cyc;
        int   lat;
    } exp_t;

    exp_t q[$];

    redmule_tiling_engine #(.ARRAY_HEIGHT(AH0), .PIPE_REGS(PR0), .SIZE_W(16)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .m_size_i(m_size), .n_size_i(n_size), .k_size_i(k_size), .fmt_i(fmt),
        .busy_o(busy[0]), .valid_o(valid[0]), .ready_i(ready), .err_o(err[0]),
        .x_rows_iter_o(xr[0]), .x_cols_iter_o(xc[0]), .w_cols_iter_o(wc[0]),
        .x_rows_lft_o(xrl[0]), .x_cols_lft_o(xcl[0]), .w_cols_lft_o(wcl[0]),
        .tot_stores_o(st[0]), .x_d1_stride_o(xd[0]), .w_d0_stride_o(wd[0])
    );

    redmule_tiling_engine #(.ARRAY_HEIGHT(AH1), .PIPE_REGS(PR1), .SIZE_W(16)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .m_size_i(m_size), .n_size_i(n_size), .k_size_i(k_size), .fmt_i(fmt),
        .busy_o(busy[1]), .valid_o(valid[1]), .ready_i(ready), .err_o(err[1]),
        .x_rows_iter_o(xr[1]), .x_cols_iter_o(xc[1]), .w_cols_iter_o(wc[1]),
        .x_rows_lft_o(xrl[1]), .x_cols_lft_o(xcl[1]), .w_cols_lft_o(wcl[1]),
        .tot_stores_o(st[1]), .x_d1_stride_o(xd[1]), .w_d0_stride_o(wd[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the tiling rules written with plain integer arithmetic.
    function automatic res_t model(input int m, input int n, input int k, input int f,
                                   input int ah, input int pr);
        res_t r;
        int aw, tile, bytes;
        aw    = ah * pr;
        tile  = ah * (pr + 1);
        bytes = (f == 1 || f == 3) ? 2 : 1;
        r = '{default: 64'd0};
        if (m == 0 || n == 0 || k == 0) begin
            r.err = 64'd1;
        end else begin
            r.xr  = 64'((m + aw - 1) / aw);
            r.xc  = 64'((n + ah - 1) / ah);
            r.wc  = 64'((k + tile - 1) / tile);
            r.xrl = 64'(m % aw);
            r.xcl = 64'(n % ah);
            r.wcl = 64'(k % tile);
            r.st  = r.xr * r.wc;
            r.xd  = 64'(n * bytes);
            r.wd  = 64'(k * bytes);
        end
        return r;
    endfunction

    function automatic res_t got(input int i);
        res_t r;
        r.err = 64'(err[i]);
        r.xr  = 64'(xr[i]);
        r.xc  = 64'(xc[i]);
        r.wc  = 64'(wc[i]);
        r.xrl = 64'(xrl[i]);
        r.xcl = 64'(xcl[i]);
        r.wcl = 64'(wcl[i]);
        r.st  = 64'(st[i]);
        r.xd  = 64'(xd[i]);
        r.wd  = 64'(wd[i]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] g, input logic [63:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, g, e, cyc);
        end
    endtask

    task automatic cmp_res(input string tag, input res_t g, input res_t e);
        chk({tag, "_err"}, g.err, e.err);
        chk({tag, "_xr_iter"}, g.xr, e.xr);
        chk({tag, "_xc_iter"}, g.xc, e.xc);
        chk({tag, "_wc_iter"}, g.wc, e.wc);
        chk({tag, "_xr_lft"}, g.xrl, e.xrl);
        chk({tag, "_xc_lft"}, g.xcl, e.xcl);
        chk({tag, "_wc_lft"}, g.wcl, e.wcl);
        chk({tag, "_stores"}, g.st, e.st);
        chk({tag, "_x_d1"}, g.xd, e.xd);
        chk({tag, "_w_d0"}, g.wd, e.wd);
    endtask

    task automatic chk_cleared(input string tag);
        res_t z;
        z = '{default: 64'd0};
        for (int i = 0; i < 2; i++) begin
            cmp_res(tag, got(i), z);
            chk({tag, "_busy"}, 64'(busy[i]), 64'd0);
            chk({tag, "_valid"}, 64'(valid[i]), 64'd0);
        end
    endtask

    // Monitor: runs on the falling edge, where both the outputs and the
    // inputs for the next rising edge are stable.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid[0]) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = q[0];
                if (!prev_valid) begin
                    chk("latency", 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
                end
                chk("busy_in_done", 64'(busy[0]), 64'd0);
                chk("valid_aligned", 64'(valid[1]), 64'd1);
                cmp_res("dut0", got(0), e.r0);
                cmp_res("dut1", got(1), e.r1);
                if (ready) begin
                    void'(q.pop_front());
                end
            end
        end
        prev_valid = rst ? 1'b0 : valid[0];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one start in IDLE and push the expected result. After acceptance
    // the inputs are scrambled; the scrambled values must have no effect.
    task automatic run(input int m, input int n, input int k, input int f);
        exp_t e;
        m_size = 16'(m);
        n_size = 16'(n);
        k_size = 16'(k);
        fmt    = 2'(f);
        start  = 1'b1;
        e.r0 = model(m, n, k, f, AH0, PR0);
        e.r1 = model(m, n, k, f, AH1, PR1);
        e.acc_cyc = cyc + 1;
        e.lat = (m == 0 || n == 0 || k == 0) ? 1 : 65;
        q.push_back(e);
        step();
        start  = 1'b0;
        m_size = 16'($urandom);
        n_size = 16'($urandom);
        k_size = 16'($urandom);
        fmt    = 2'($urandom);
        if (e.lat != 1) begin
            chk("busy_after_start", 64'(busy[0]), 64'd1);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            if (q.size() == 0) break;
            step();
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, n, k;
        repeat (3) step();
        chk_cleared("reset");
        rst = 1'b0;
        step();

        run(96, 64, 100, 1);  wait_drain();
        run(50, 12, 37, 0);   wait_drain();
        run(0, 5, 5, 1);      wait_drain();
        run(7, 0, 9, 2);      wait_drain();
        run(1, 1, 1, 3);      wait_drain();

        // Hold the result, with a start pulse while busy and a start in DONE.
        ready = 1'b0;
        run(100, 200, 300, 3);
        repeat (18) step();
        start = 1'b1;
        m_size = 16'd5;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (valid[0]) break;
            step();
        end
        chk("hold_valid_seen", 64'(valid[0]), 64'd1);
        repeat (10) step();
        start = 1'b1;
        ready = 1'b1;
        m_size = 16'd9;
        n_size = 16'd9;
        k_size = 16'd9;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("no_start_from_done_busy", 64'(busy[0]), 64'd0);
        chk("no_start_from_done_valid", 64'(valid[0]), 64'd0);
        chk("queue_popped", 64'(q.size()), 64'd0);
        run(300, 100, 200, 0); wait_drain();

        // Reset in the middle of a run.
        run(1000, 2000, 3000, 1);
        repeat (29) step();
        rst = 1'b1;
        step();
        chk_cleared("mid_reset");
        rst = 1'b0;
        q.delete();
        step();
        run(65535, 65535, 65535, 1); wait_drain();

        // Random runs, some with a zero size and some with ready held low.
        for (int r = 0; r < 16; r++) begin
            m = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 65535));
            n = int'($urandom_range(1, 65535));
            k = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 400));
            ready = ($urandom_range(0, 2) != 0);
            run(m, n, k, int'($urandom_range(0, 3)));
            if (!ready) begin
                repeat (int'($urandom_range(66, 75))) step();
                ready = 1'b1;
            end
            wait_drain();
        end

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
